// File: rtl/sync_pair_join.sv
// sync_pair_join: buffers two branches and joins one token from each into {in2, in1}.
// Latency: result valid FL cycles after the pair pop; next pop no earlier than BL+1 cycles after the output handshake.
// Backpressure: each branch deasserts ready when its FIFO is full; out_ready low holds the result in SEND.

// Per-branch FIFO: in-order storage, push and pop independent, no full bypass.
// Latency: a push at edge E is visible at the head from edge E+1.
// Backpressure: full is raised from the current count; the caller must not push when full.
module sync_pair_join_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage array needs no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module sync_pair_join #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int FL    = 2,
    parameter int BL    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in1_data,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [WIDTH-1:0]   in2_data,
    input  logic               in2_valid,
    output logic               in2_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        join_count
);
    typedef enum logic [1:0] {IDLE, WAIT_FL, SEND, WAIT_BL} state_t;

    state_t           state;
    logic [3:0]       timer;
    logic             full1;
    logic             full2;
    logic             empty1;
    logic             empty2;
    logic [WIDTH-1:0] head1;
    logic [WIDTH-1:0] head2;
    logic             push1;
    logic             push2;
    logic             pop_pair;

    assign in1_ready = rst_n && !full1;
    assign in2_ready = rst_n && !full2;
    assign push1     = in1_valid && in1_ready;
    assign push2     = in2_valid && in2_ready;
    // Both heads leave together, and only while idle; a lone token waits for its partner.
    assign pop_pair  = (state == IDLE) && !empty1 && !empty2;

    sync_pair_join_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_data (in1_data),
        .push      (push1),
        .pop       (pop_pair),
        .head      (head1),
        .full      (full1),
        .empty     (empty1)
    );

    sync_pair_join_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_data (in2_data),
        .push      (push2),
        .pop       (pop_pair),
        .head      (head2),
        .full      (full2),
        .empty     (empty2)
    );

    // Join sequencing: pop pair, wait FL, present until taken, wait BL, repeat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            join_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_pair) begin
                        out_data <= {head2, head1};
                        if (FL == 0) begin
                            state     <= SEND;
                            out_valid <= 1'b1;
                        end else begin
                            timer <= 4'(FL);
                            state <= WAIT_FL;
                        end
                    end
                end
                WAIT_FL: begin
                    timer <= timer - 4'd1;
                    if (timer == 4'd1) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        join_count <= join_count + 16'd1;
                        if (BL == 0) begin
                            state <= IDLE;
                        end else begin
                            timer <= 4'(BL);
                            state <= WAIT_BL;
                        end
                    end
                end
                WAIT_BL: begin
                    timer <= timer - 4'd1;
                    if (timer == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
